// File: rtl/ps2_key_tx.sv
// PS/2 device-side key transmitter: key events become scan-code bytes in a FIFO, sent as 11-bit frames.
// Optional host-inhibit/abort support is enabled with `define PS2_TX_INHIBIT_EN (adds input ps2_clk_in).
module ps2_key_tx #(
    parameter int CLK_DIV    = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int BYTE_GAP   = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
`ifdef PS2_TX_INHIBIT_EN
    input  logic        ps2_clk_in,
`endif
    output logic        ps2_clk_out,
    output logic        ps2_dat_out,
    output logic        busy,
    output logic        overflow,
    output logic [1:0]  state_dbg_o
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int GAP_CYC  = BYTE_GAP * CLK_DIV;
    localparam int CNT_MAX  = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BIT = 2'd1, S_GAP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic          phase_q, phase_d;   // 0 = clock-high half, 1 = clock-low half
    logic [3:0]    bit_q, bit_d;
    logic [10:0]   frame_q, frame_d;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          toggle_q;
    logic          overflow_q;

    logic [AW:0]   count, free, wr1, wr2;
    logic          fifo_empty, event_det, accept, pop, hold;
    logic [1:0]    seq_len;
    logic [7:0]    seq_b0, seq_b1, seq_b2, head;
    logic [10:0]   load_frame;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign free       = (AW+1)'(FIFO_DEPTH) - count;
    assign fifo_empty = (count == '0);
    assign wr1        = wr_ptr_q + (AW+1)'(1);
    assign wr2        = wr_ptr_q + (AW+1)'(2);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign load_frame = {1'b1, ~^head, head, 1'b0};

    assign event_det  = ps2_key[10] ^ toggle_q;
    assign seq_len    = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
    assign accept     = event_det && (free >= (AW+1)'(seq_len));

    always_comb begin
        seq_b0 = ps2_key[7:0];
        seq_b1 = ps2_key[7:0];
        seq_b2 = ps2_key[7:0];
        case ({ps2_key[8], ~ps2_key[9]})
            2'b01:   seq_b0 = 8'hF0;
            2'b10:   seq_b0 = 8'hE0;
            2'b11:   begin seq_b0 = 8'hE0; seq_b1 = 8'hF0; end
            default: ;
        endcase
    end

`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] clk_sync_q;
    always_ff @(posedge clk_sys) begin
        if (reset) clk_sync_q <= 2'b11;
        else       clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
    end
    assign hold = ~clk_sync_q[1];
`else
    assign hold = 1'b0;
`endif

    // Whole sequence lands in one cycle; accept guarantees room for all of it.
    always_ff @(posedge clk_sys) begin
        if (!reset && accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= seq_b0;
            if (seq_len > 2'd1) mem_q[wr1[AW-1:0]] <= seq_b1;
            if (seq_len > 2'd2) mem_q[wr2[AW-1:0]] <= seq_b2;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !hold) begin
                    state_d = S_BIT;
                    frame_d = load_frame;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = 4'd0;
                end
            end
            S_BIT: begin
                if (hold && !phase_q && bit_q != 4'd10) begin
                    state_d = S_GAP;
                    div_d   = '0;
                end else if (div_q == CW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 4'd10) begin
                            pop     = 1'b1;
                            state_d = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            frame_d = {1'b1, frame_q[10:1]};
                        end
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            S_GAP: begin
                // Chaining straight into the next frame keeps the frame pitch at (22+BYTE_GAP) half-bits.
                if (div_q == CW'(GAP_LAST)) begin
                    div_d = '0;
                    if (!fifo_empty && !hold) begin
                        state_d = S_BIT;
                        frame_d = load_frame;
                        phase_d = 1'b0;
                        bit_d   = 4'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= 4'd0;
            frame_q    <= '1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            toggle_q   <= ps2_key[10];
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            toggle_q   <= ps2_key[10];
            overflow_q <= event_det & ~accept;
            if (accept) wr_ptr_q <= wr_ptr_q + (AW+1)'(seq_len);
            if (pop)    rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    assign ps2_clk_out = (state_q == S_BIT) ? ~phase_q   : 1'b1;
    assign ps2_dat_out = (state_q == S_BIT) ? frame_q[0] : 1'b1;
    assign busy        = !fifo_empty || (state_q != S_IDLE);
    assign overflow    = overflow_q;
    assign state_dbg_o = state_q;

endmodule
